uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in the rx input synchronizer, minimum 2.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port div_clk_en  input  1  one-clk pulse at 16x baud rate; the only sampling/tick qualifier.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port rx_valid  output  1  one-clk pulse when a character completes.
REQ-007 SHALL have port rx_data  output  8  received character, LSB-first assembled, zero-extended above word length.
REQ-008 SHALL have port rx_parity_err  output  1  parity mismatch for that character.
REQ-009 SHALL have port rx_frame_err  output  1  first stop bit sampled low.
REQ-010 SHALL have port rx_break  output  1  data, parity (if enabled) and stop all sampled low.
REQ-011 SHALL have port cfg_word_len  input  uart_pkg::word_len_e  5/6/7/8 data bits.
REQ-012 SHALL have ports cfg_parity_en, cfg_parity_even, cfg_parity_stick  input  1 each  parity enable, even select, stick parity.

Function
REQ-013 SHALL pass rx through SYNC_STAGES flops (reset value 1); all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BRK_WAIT with a 4-bit tick counter advanced only on div_clk_en.
REQ-015 IDLE: on a div_clk_en with synchronized rx low, go START, counter cleared to 0.
REQ-016 START: at 8th tick (counter 7) sample; high -> false start, return IDLE with no output; low -> latch all cfg_* inputs, clear counter, go DATA.
REQ-017 DATA/PARITY/STOP: sample one bit each 16 ticks (counter 15), i.e. at bit centre; DATA takes exactly latched word length bits, LSB first.
REQ-018 PARITY entered only if latched cfg_parity_en; else DATA -> STOP directly.
REQ-019 Expected parity bit: stick -> ~cfg_parity_even; else even -> XOR of data bits, odd -> its inverse; mismatch sets rx_parity_err; 0 when parity disabled.
REQ-020 Only the first stop bit is checked, regardless of stop-bit configuration.
REQ-021 rx_valid, rx_data and all error flags SHALL be registered, asserted the clk after the stop-sample cycle; rx_valid high exactly 1 clk; data/flags hold until the next rx_valid.
REQ-022 After stop sample: rx_break -> BRK_WAIT until synchronized rx high on a div_clk_en, then IDLE; otherwise IDLE immediately, so a low line starts the next frame with no gap.
REQ-023 cfg_* changes mid-frame SHALL NOT affect the frame in progress.
REQ-024 div_clk_en low SHALL freeze counter and state; clk-rate rx glitches narrower than one tick are ignored unless sampled.

Reset
REQ-025 rst SHALL force state IDLE, counter 0, synchronizer to 1, rx_valid/rx_parity_err/rx_frame_err/rx_break 0, rx_data 0, discarding any partial frame.
REQ-026 After rst deasserts, a line already low SHALL be treated as a start bit only via REQ-015 (no frame emitted without full START validation).

Structure
REQ-027 word_len_e (existing) and new rx_state_e SHALL live in uart_pkg; tick-count constants (MID=7, FULL=15) SHALL be package localparams.
REQ-028 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, reset value).

Verification
REQ-029 8N1, byte 0xA5, 16 ticks/bit -> one rx_valid, rx_data=0xA5, all flags 0, pulse 1 clk after stop centre.
REQ-030 7E1, data 0x41, parity bit sent 1 (wrong) -> rx_data=0x41, rx_parity_err=1; same with parity 0 -> 0.
REQ-031 8N1 0x3C with stop bit low -> rx_frame_err=1, rx_break=0; then line high -> next 0x55 frame received clean.
REQ-032 Start pulse low 4 ticks then high -> no rx_valid, state back to IDLE.
REQ-033 Line low 2 frame times then high -> single rx_valid, rx_data=0x00, rx_break=1, rx_frame_err=1; no further rx_valid until line high and a new start.
REQ-034 rst asserted mid-DATA, then full 8N1 0xFF -> only 0xFF reported; back-to-back 0x01,0x02 with no idle gap -> two rx_valid exactly 160 ticks apart.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and tick constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        WL_5 = 2'd0,
        WL_6 = 2'd1,
        WL_7 = 2'd2,
        WL_8 = 2'd3
    } word_len_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam logic [3:0] TICK_MID  = 4'd7;
    localparam logic [3:0] TICK_FULL = 4'd15;

    // Index of the final data bit: 5 bits -> 4 ... 8 bits -> 7.
    function automatic logic [2:0] last_bit_idx(input word_len_e wl);
        return {1'b1, wl};
    endfunction

    function automatic logic exp_parity(input logic acc, input logic even, input logic stick);
        if (stick) return ~even;
        return even ? acc : ~acc;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-character bus: one-clk valid strobe plus data and error flags that hold between strobes.
interface uart_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_break;

    modport master (output rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break);
    modport slave  (input  rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break);
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= {STAGES{RST_VAL}};
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start validation at mid-bit, 5-8 data bits, optional parity,
// first stop bit checked, break detection with wait-for-idle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_clk_en,
    input  logic       rx,
    input  word_len_e  cfg_word_len,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_even,
    input  logic       cfg_parity_stick,
    uart_rx_if.master  rx_bus
);

    logic rx_sync;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_sync)
    );

    rx_state_e  state_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shreg_q;
    word_len_e  wl_q;
    logic       pen_q, peven_q, pstick_q;
    logic       par_acc_q, all_low_q, perr_q;

    logic       valid_q;
    logic [7:0] data_q;
    logic       perr_out_q, ferr_q, brk_q;

    logic       tick_full;
    logic [7:0] shreg_d;
    logic       brk_d;

    assign tick_full = (cnt_q == TICK_FULL);
    assign brk_d     = all_low_q & ~rx_sync;

    always_comb begin
        shreg_d            = shreg_q;
        shreg_d[bit_idx_q] = rx_sync;
    end

    // Frame datapath registers are not reset; they are reinitialised on every validated start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (div_clk_en) begin
                cnt_q <= cnt_q + 4'd1;
                unique case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (!rx_sync) state_q <= START;
                    end
                    START: begin
                        if (cnt_q == TICK_MID) begin
                            cnt_q <= '0;
                            if (rx_sync) begin
                                state_q <= IDLE;
                            end else begin
                                wl_q      <= cfg_word_len;
                                pen_q     <= cfg_parity_en;
                                peven_q   <= cfg_parity_even;
                                pstick_q  <= cfg_parity_stick;
                                bit_idx_q <= '0;
                                shreg_q   <= '0;
                                par_acc_q <= 1'b0;
                                all_low_q <= 1'b1;
                                perr_q    <= 1'b0;
                                state_q   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (tick_full) begin
                            shreg_q   <= shreg_d;
                            par_acc_q <= par_acc_q ^ rx_sync;
                            all_low_q <= all_low_q & ~rx_sync;
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == last_bit_idx(wl_q))
                                state_q <= pen_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (tick_full) begin
                            perr_q    <= rx_sync ^ exp_parity(par_acc_q, peven_q, pstick_q);
                            all_low_q <= all_low_q & ~rx_sync;
                            state_q   <= STOP;
                        end
                    end
                    STOP: begin
                        if (tick_full) begin
                            valid_q    <= 1'b1;
                            data_q     <= shreg_q;
                            perr_out_q <= perr_q;
                            ferr_q     <= ~rx_sync;
                            brk_q      <= brk_d;
                            state_q    <= brk_d ? BRK_WAIT : IDLE;
                        end
                    end
                    BRK_WAIT: begin
                        cnt_q <= '0;
                        if (rx_sync) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rx_bus.rx_valid      = valid_q;
    assign rx_bus.rx_data       = data_q;
    assign rx_bus.rx_parity_err = perr_out_q;
    assign rx_bus.rx_frame_err  = ferr_q;
    assign rx_bus.rx_break      = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model predicts each character, its flags and its tick.
module tb_uart_rx;
    import uart_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      div_clk_en = 1'b0;
    logic      rx = 1'b1;
    word_len_e cfg_word_len = WL_8;
    logic      cfg_parity_en = 1'b0;
    logic      cfg_parity_even = 1'b0;
    logic      cfg_parity_stick = 1'b0;

    uart_rx_if bus();

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .div_clk_en       (div_clk_en),
        .rx               (rx),
        .cfg_word_len     (cfg_word_len),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_parity_even  (cfg_parity_even),
        .cfg_parity_stick (cfg_parity_stick),
        .rx_bus           (bus)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, changed on the falling edge.
    initial begin : tickgen
        int d;
        d = 0;
        forever begin
            @(negedge clk);
            d = (d + 1) % 4;
            div_clk_en = (d == 0);
        end
    end

    int   tick_no = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        if (div_clk_en) tick_no <= tick_no + 1;
        rst_seen <= rst;
    end

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         tick;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    int last_tick = 0;
    int prev_tick = 0;
    logic       chk_en = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_perr = 1'b0, held_ferr = 1'b0, held_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] d, input int wl, input logic even,
                                          input logic stick);
        logic [7:0] m;
        logic       x;
        if (stick) return ~even;
        m = 8'((9'd1 << wl) - 9'd1);
        x = ^(d & m);
        return even ? x : ~x;
    endfunction

    // Character expected from a frame whose start bit is driven just after tick k.
    task automatic push_expect(input int wl, input logic [7:0] d, input logic pen, input logic even,
                               input logic stick, input logic par_bit, input logic stop_val,
                               input int k);
        exp_t e;
        e.data = d & 8'((9'd1 << wl) - 9'd1);
        e.perr = pen && (par_bit != model_parity(d, wl, even, stick));
        e.ferr = !stop_val;
        e.brk  = (e.data == 8'h00) && (!pen || !par_bit) && !stop_val;
        e.tick = k + 9 + 16 * (1 + wl + (pen ? 1 : 0));
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (div_clk_en) c++;
        end
        #1;
    endtask

    task automatic set_cfg(input int wl, input logic pen, input logic even, input logic stick);
        cfg_word_len     = word_len_e'(2'(wl - 5));
        cfg_parity_en    = pen;
        cfg_parity_even  = even;
        cfg_parity_stick = stick;
    endtask

    task automatic send(input int wl, input logic [7:0] d, input logic pen, input logic even,
                        input logic stick, input logic par_bit, input logic stop_val);
        set_cfg(wl, pen, even, stick);
        push_expect(wl, d, pen, even, stick, par_bit, stop_val, tick_no);
        rx = 1'b0;
        hold(16);
        // Scramble configuration once the frame is under way.
        set_cfg(13 - wl, ~pen, ~even, ~stick);
        for (int i = 0; i < wl; i++) begin
            rx = d[i];
            hold(16);
        end
        if (pen) begin
            rx = par_bit;
            hold(16);
        end
        rx = stop_val;
        hold(16);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin : cmp
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (rst_seen) begin
                    held_data = 8'h00;
                    held_perr = 1'b0;
                    held_ferr = 1'b0;
                    held_brk  = 1'b0;
                    check("reset_outputs",
                          32'({bus.rx_valid, bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, bus.rx_break}),
                          32'd0);
                end else if (bus.rx_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 32'(bus.rx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 32'(bus.rx_data), 32'(e.data));
                        check("rx_parity_err", 32'(bus.rx_parity_err), 32'(e.perr));
                        check("rx_frame_err", 32'(bus.rx_frame_err), 32'(e.ferr));
                        check("rx_break", 32'(bus.rx_break), 32'(e.brk));
                        check("valid_tick", 32'(tick_no), 32'(e.tick));
                        held_data = e.data;
                        held_perr = e.perr;
                        held_ferr = e.ferr;
                        held_brk  = e.brk;
                    end
                    prev_tick = last_tick;
                    last_tick = tick_no;
                    n_valid++;
                end else begin
                    check("hold_outputs",
                          32'({bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, bus.rx_break}),
                          32'({held_data, held_perr, held_ferr, held_brk}));
                    if (exp_q.size() != 0 && tick_no > exp_q[0].tick + 1) begin
                        e = exp_q.pop_front();
                        check("missed_valid_tick", 32'(tick_no), 32'(e.tick));
                    end
                end
            end
        end
    end

    initial begin : main
        int k0;
        int nv;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_state",
              32'({bus.rx_valid, bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, bus.rx_break}), 32'd0);
        rst = 1'b0;
        hold(4);

        // 8N1 0xA5
        k0 = tick_no;
        send(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check("a5_data", 32'(held_data), 32'h0000_00A5);
        check("a5_flags", 32'({held_perr, held_ferr, held_brk}), 32'd0);
        check("a5_latency", 32'(last_tick - k0), 32'd153);

        // 7E1 0x41, wrong then right parity
        send(7, 8'h41, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
        check("7e1_bad_perr", 32'(held_perr), 32'd1);
        check("7e1_bad_data", 32'(held_data), 32'h41);
        send(7, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        check("7e1_good_perr", 32'(held_perr), 32'd0);

        // Other word lengths and parity modes
        send(5, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(6, 8'h2A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send(6, 8'h15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drain();

        // Framing error then clean frame
        send(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        hold(20);
        drain();
        check("3c_ferr", 32'(held_ferr), 32'd1);
        check("3c_brk", 32'(held_brk), 32'd0);
        send(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check("55_after_ferr", 32'({held_data, held_ferr}), 32'({8'h55, 1'b0}));

        // False start and sub-tick glitch
        nv = n_valid;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(30);
        rx = 1'b0;
        #10;
        rx = 1'b1;
        hold(30);
        check("false_start_no_valid", 32'(n_valid - nv), 32'd0);
        send(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Break: line low two frame times
        set_cfg(8, 1'b0, 1'b0, 1'b0);
        nv = n_valid;
        push_expect(8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tick_no);
        rx = 1'b0;
        hold(320);
        rx = 1'b1;
        hold(40);
        drain();
        check("break_count", 32'(n_valid - nv), 32'd1);
        check("break_flags", 32'({held_data, held_brk, held_ferr}), 32'({8'h00, 1'b1, 1'b1}));

        // Reset mid-DATA, then a full frame
        nv = n_valid;
        rx = 1'b0;
        hold(16);
        rx = 1'b1;
        hold(16);
        rx = 1'b0;
        hold(8);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx = 1'b1;
        hold(20);
        send(8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check("after_rst_count", 32'(n_valid - nv), 32'd1);
        check("after_rst_data", 32'(held_data), 32'hFF);

        // Back-to-back, no idle gap
        send(8, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(8, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        check("b2b_spacing", 32'(last_tick - prev_tick), 32'd160);
        check("b2b_data", 32'(held_data), 32'h02);

        hold(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
